// File: rtl/pdp8_memctl.sv
// pdp8_memctl: memory cycle sequencer between the PDP-8 CPU core and the
// async SRAM interface. Each accepted request runs IDLE -> SETUP -> PULSE ->
// HOLD -> ACK, with setup/pulse/hold lengths set by parameters (0 acts as 1).
// Address and write data are latched once on acceptance and stay frozen until
// the next acceptance, so the SRAM never sees them move under a strobe.
// Optional build macro MEMCTL_STATS_EN adds read/write completion counters.
module pdp8_memctl #(
  parameter logic [3:0] SETUP_CYC = 4'd1,
  parameter logic [3:0] PULSE_CYC = 4'd2,
  parameter logic [3:0] HOLD_CYC  = 4'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [14:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic [11:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_busy,
  output logic [14:0] ram_addr,
  output logic [11:0] ram_wdata,
  input  logic [11:0] ram_rdata,
  output logic        ram_rd,
  output logic        ram_wr
`ifdef MEMCTL_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_rd_cnt,
  output logic [15:0] stat_wr_cnt
`endif
);

  // A programmed length of zero behaves as a single cycle.
  localparam logic [3:0] SETUP_EFF = (SETUP_CYC == 4'd0) ? 4'd1 : SETUP_CYC;
  localparam logic [3:0] PULSE_EFF = (PULSE_CYC == 4'd0) ? 4'd1 : PULSE_CYC;
  localparam logic [3:0] HOLD_EFF  = (HOLD_CYC  == 4'd0) ? 4'd1 : HOLD_CYC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [14:0] ram_addr_q, ram_addr_d;
  logic [11:0] ram_wdata_q, ram_wdata_d;
  logic        ram_rd_q, ram_rd_d;
  logic        ram_wr_q, ram_wr_d;
  logic [11:0] rd_hold_q, rd_hold_d;
  logic [11:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        cpu_busy_q, cpu_busy_d;
  logic        cnt_last;

  // The counter is loaded with the phase length and the phase ends on its
  // last cycle (count of one), so each phase lasts exactly its loaded length.
  assign cnt_last = (cnt_q == 4'd1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      rd_hold_q   <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_busy_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      rd_hold_q   <= rd_hold_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_busy_q  <= cpu_busy_d;
    end
  end

  // Next-state and next-output logic; every registered output is computed one
  // cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_rd_d    = ram_rd_q;
    ram_wr_d    = ram_wr_q;
    rd_hold_d   = rd_hold_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    cpu_busy_d  = cpu_busy_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          op_wr_d     = cpu_wr;
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_wdata;
          cpu_busy_d  = 1'b1;
          cnt_d       = SETUP_EFF;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_last) begin
          ram_rd_d = ~op_wr_q;
          ram_wr_d = op_wr_q;
          cnt_d    = PULSE_EFF;
          state_d  = ST_PULSE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_last) begin
          // Sample read data on the final strobe cycle, when the SRAM has
          // had the full pulse width to drive it.
          if (!op_wr_q) begin
            rd_hold_d = ram_rdata;
          end
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          cnt_d    = HOLD_EFF;
          state_d  = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          if (!op_wr_q) begin
            cpu_rdata_d = rd_hold_q;
          end
          cpu_ack_d = 1'b1;
          state_d   = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        cpu_busy_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        ram_rd_d   = 1'b0;
        ram_wr_d   = 1'b0;
        cpu_busy_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_busy  = cpu_busy_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_rd    = ram_rd_q;
  assign ram_wr    = ram_wr_q;

`ifdef MEMCTL_STATS_EN
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;

  // Completion counters: bump in the ACK cycle, clear wins over a bump.
  always_comb begin
    stat_rd_d = stat_rd_q;
    stat_wr_d = stat_wr_q;
    if (stat_clr) begin
      stat_rd_d = '0;
      stat_wr_d = '0;
    end else if (state_q == ST_ACK) begin
      if (op_wr_q) begin
        stat_wr_d = stat_wr_q + 16'd1;
      end else begin
        stat_rd_d = stat_rd_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd_cnt = stat_rd_q;
  assign stat_wr_cnt = stat_wr_q;
`endif

endmodule

// File: tb/tb_pdp8_memctl.sv
// Scoreboard bench for pdp8_memctl: instance A uses default timing, instance B
// uses SETUP=2, PULSE=3, HOLD=0. Stimulus pushes expected transactions into a
// queue; per-DUT monitors on the falling edge check every cycle's pins against
// the queue head. Define MEMCTL_STATS_EN to also exercise the counters.
module tb_pdp8_memctl;

  localparam int SB_CFG = 2;
  localparam int PB_CFG = 3;
  localparam int HB_CFG = 0;
  localparam int SA = 1, PA = 2, HA = 1;
  localparam int SB = (SB_CFG == 0) ? 1 : SB_CFG;
  localparam int PB = (PB_CFG == 0) ? 1 : PB_CFG;
  localparam int HB = (HB_CFG == 0) ? 1 : HB_CFG;
  localparam int LAT_A = 1 + SA + PA + HA;
  localparam int LAT_B = 1 + SB + PB + HB;

  typedef struct {
    bit          wr;
    logic [14:0] addr;
    logic [11:0] wdata;
    logic [11:0] rdata;
    int          issue;
    int          ack;
  } txn_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_a = 1'b0, wr_a = 1'b0;
  logic [14:0] addr_a = '0;
  logic [11:0] wdata_a = '0;
  logic [11:0] rdata_a, rwdata_a, rrdata_a;
  logic [14:0] raddr_a;
  logic        ack_a, busy_a, rrd_a, rwr_a;

  logic        req_b = 1'b0, wr_b = 1'b0;
  logic [14:0] addr_b = '0;
  logic [11:0] wdata_b = '0;
  logic [11:0] rdata_b, rwdata_b, rrdata_b;
  logic [14:0] raddr_b;
  logic        ack_b, busy_b, rrd_b, rwr_b;

`ifdef MEMCTL_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_rd_cnt, stat_wr_cnt;
  int          m_rd = 0, m_wr = 0;
`endif

  pdp8_memctl #(.SETUP_CYC(4'd1), .PULSE_CYC(4'd2), .HOLD_CYC(4'd1)) u_a (
    .clk(clk), .reset_n(reset_n), .cpu_req(req_a), .cpu_wr(wr_a),
    .cpu_addr(addr_a), .cpu_wdata(wdata_a), .cpu_rdata(rdata_a),
    .cpu_ack(ack_a), .cpu_busy(busy_a), .ram_addr(raddr_a),
    .ram_wdata(rwdata_a), .ram_rdata(rrdata_a), .ram_rd(rrd_a), .ram_wr(rwr_a)
`ifdef MEMCTL_STATS_EN
    , .stat_clr(stat_clr), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  pdp8_memctl #(.SETUP_CYC(4'(SB_CFG)), .PULSE_CYC(4'(PB_CFG)), .HOLD_CYC(4'(HB_CFG))) u_b (
    .clk(clk), .reset_n(reset_n), .cpu_req(req_b), .cpu_wr(wr_b),
    .cpu_addr(addr_b), .cpu_wdata(wdata_b), .cpu_rdata(rdata_b),
    .cpu_ack(ack_b), .cpu_busy(busy_b), .ram_addr(raddr_b),
    .ram_wdata(rwdata_b), .ram_rdata(rrdata_b), .ram_rd(rrd_b), .ram_wr(rwr_b)
`ifdef MEMCTL_STATS_EN
    , .stat_clr(1'b0), .stat_rd_cnt(), .stat_wr_cnt()
`endif
  );

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit mon_on = 1'b0;
  txn_t qa[$];
  txn_t qb[$];
  int next_free_a = 0, next_free_b = 0;
  logic [11:0] last_rd_a = '0, last_rd_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Background SRAM contents for never-written locations.
  function automatic logic [11:0] pat(input logic [14:0] a);
    if (a == 15'o00200) return 12'o4321;
    return a[11:0] ^ {a[14:12], a[14:12], a[14:12], a[14:12]} ^ 12'o2525;
  endfunction

  // SRAM model A: write while the write strobe is high; read data becomes
  // valid only after the read strobe has been high for one cycle.
  bit [11:0] mem_a [32768];
  bit        wv_a  [32768];
  int        age_a = 0, age_b = 0;
  logic [11:0] cell_a;
  always @(posedge clk) begin
    if (rwr_a) begin
      mem_a[raddr_a] <= rwdata_a;
      wv_a[raddr_a]  <= 1'b1;
    end
    age_a <= rrd_a ? age_a + 1 : 0;
    age_b <= rrd_b ? age_b + 1 : 0;
  end
  assign cell_a   = wv_a[raddr_a] ? mem_a[raddr_a] : pat(raddr_a);
  assign rrdata_a = (rrd_a && age_a >= PA - 1) ? cell_a : ~cell_a;
  assign rrdata_b = (rrd_b && age_b >= PB - 1) ? pat(raddr_b) : ~pat(raddr_b);

  // Reference memory for instance A, updated in program order.
  bit [11:0] ref_mem [32768];
  bit        ref_v   [32768];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] rand_addr();
    return {3'($urandom_range(0, 7)), 8'o05, 4'($urandom_range(0, 15))};
  endfunction

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request on A once the model says it is idle, optionally poking
  // an extra request during the busy window that must be ignored.
  task automatic access_a(input bit wr, input logic [14:0] addr, input logic [11:0] wdata,
                          input int gap, input bit junk);
    txn_t t;
    int k;
    wait_cyc(((cyc > next_free_a) ? cyc : next_free_a) + gap);
    req_a = 1'b1; wr_a = wr; addr_a = addr; wdata_a = wdata;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.issue = cyc; t.ack = cyc + LAT_A;
    if (wr) begin
      ref_mem[addr] = wdata;
      ref_v[addr]   = 1'b1;
    end else begin
      last_rd_a = ref_v[addr] ? ref_mem[addr] : pat(addr);
    end
    t.rdata = last_rd_a;
    qa.push_back(t);
    next_free_a = t.ack + 1;
    @(posedge clk); #1;
    req_a = 1'b0; wr_a = 1'($urandom); addr_a = 15'($urandom); wdata_a = 12'($urandom);
    if (junk) begin
      k = $urandom_range(1, LAT_A);
      wait_cyc(t.issue + k);
      req_a = 1'b1; wr_a = 1'($urandom); addr_a = 15'($urandom); wdata_a = 12'($urandom);
      @(posedge clk); #1;
      req_a = 1'b0;
    end
  endtask

  task automatic access_b(input bit wr, input logic [14:0] addr, input logic [11:0] wdata,
                          input int junk_off);
    txn_t t;
    wait_cyc((cyc > next_free_b) ? cyc : next_free_b);
    req_b = 1'b1; wr_b = wr; addr_b = addr; wdata_b = wdata;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.issue = cyc; t.ack = cyc + LAT_B;
    if (!wr) last_rd_b = pat(addr);
    t.rdata = last_rd_b;
    qb.push_back(t);
    next_free_b = t.ack + 1;
    @(posedge clk); #1;
    req_b = 1'b0; addr_b = 15'($urandom); wdata_b = 12'($urandom);
    if (junk_off > 0) begin
      wait_cyc(t.issue + junk_off);
      req_b = 1'b1; wr_b = 1'b1; addr_b = 15'o07000;
      @(posedge clk); #1;
      req_b = 1'b0;
    end
  endtask

  // Monitor A: every cycle, compare pins with the outstanding transaction.
  txn_t ta;
  bit live_a, e_rd_a, e_wr_a, e_ack_a;
  always @(negedge clk) begin
    if (mon_on) begin
      if (!reset_n) begin
        qa.delete();
`ifdef MEMCTL_STATS_EN
        m_rd = 0; m_wr = 0;
`endif
      end
      live_a = (qa.size() != 0) && (cyc > qa[0].issue);
      if (live_a) ta = qa[0];
      e_rd_a  = live_a && !ta.wr && cyc >= ta.issue + 1 + SA && cyc < ta.issue + 1 + SA + PA;
      e_wr_a  = live_a &&  ta.wr && cyc >= ta.issue + 1 + SA && cyc < ta.issue + 1 + SA + PA;
      e_ack_a = live_a && cyc == ta.ack;
      chk("pins_a{busy,rd,wr,ack}", {busy_a, rrd_a, rwr_a, ack_a}, {live_a, e_rd_a, e_wr_a, e_ack_a});
      if (live_a) begin
        chk("ram_addr_a", raddr_a, ta.addr);
        if (ta.wr) chk("ram_wdata_a", rwdata_a, ta.wdata);
      end
`ifdef MEMCTL_STATS_EN
      chk("stat_rd_cnt", stat_rd_cnt, 16'(m_rd));
      chk("stat_wr_cnt", stat_wr_cnt, 16'(m_wr));
      if (stat_clr) begin
        m_rd = 0; m_wr = 0;
      end else if (e_ack_a) begin
        if (ta.wr) m_wr = (m_wr + 1) % 65536;
        else       m_rd = (m_rd + 1) % 65536;
      end
`endif
      if (e_ack_a) begin
        chk("cpu_rdata_a", rdata_a, ta.rdata);
        void'(qa.pop_front());
      end
    end
  end

  // Monitor B: same idea for the swept-timing instance.
  txn_t tb;
  bit live_b, e_rd_b, e_wr_b, e_ack_b;
  always @(negedge clk) begin
    if (mon_on) begin
      if (!reset_n) qb.delete();
      live_b = (qb.size() != 0) && (cyc > qb[0].issue);
      if (live_b) tb = qb[0];
      e_rd_b  = live_b && !tb.wr && cyc >= tb.issue + 1 + SB && cyc < tb.issue + 1 + SB + PB;
      e_wr_b  = live_b &&  tb.wr && cyc >= tb.issue + 1 + SB && cyc < tb.issue + 1 + SB + PB;
      e_ack_b = live_b && cyc == tb.ack;
      chk("pins_b{busy,rd,wr,ack}", {busy_b, rrd_b, rwr_b, ack_b}, {live_b, e_rd_b, e_wr_b, e_ack_b});
      if (live_b) chk("ram_addr_b", raddr_b, tb.addr);
      if (e_ack_b) begin
        chk("cpu_rdata_b", rdata_b, tb.rdata);
        void'(qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_n = 1'b0;
    #1 mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_a", {rdata_a, ack_a, busy_a, raddr_a, rwdata_a, rrd_a, rwr_a}, '0);
    chk("reset_outputs_b", {rdata_b, ack_b, busy_b, raddr_b, rwdata_b, rrd_b, rwr_b}, '0);
    reset_n = 1'b1;
    next_free_a = cyc + 10;
    next_free_b = cyc + 10;

    // Directed traffic on A: write, read, back-to-back write, read-back.
    access_a(1'b1, 15'o12345, 12'o7070, 0, 1'b0);
    access_a(1'b0, 15'o00200, 12'o0000, 2, 1'b0);
    access_a(1'b1, 15'o00201, 12'o1111, 0, 1'b0);
    access_a(1'b0, 15'o12345, 12'o0000, 0, 1'b1);

    // Random traffic with random gaps and ignored requests.
    for (int i = 0; i < 40; i++) begin
      access_a(1'($urandom), rand_addr(), 12'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    // Swept timing on B: read with a request poked 3 cycles in, then a write
    // that must leave the read data alone, then another read.
    access_b(1'b0, 15'o00200, 12'o0000, 3);
    access_b(1'b1, 15'o00017, 12'o5555, 0);
    access_b(1'b0, 15'o07777, 12'o0000, 0);
    wait_cyc(next_free_b + 1);

    // Mid-access reset on A while the read strobe is high.
    access_a(1'b0, 15'o00311, 12'o0000, 1, 1'b0);
    @(posedge clk); #1;
    chk("rd_high_before_reset", rrd_a, 1'b1);
    reset_n = 1'b0;
    last_rd_a = '0;
    last_rd_b = '0;
    #1;
    chk("reset_abort_a", {rrd_a, rwr_a, busy_a, ack_a, rdata_a}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    next_free_a = cyc + 1;
    next_free_b = cyc + 1;
    access_a(1'b0, 15'o00311, 12'o0000, 0, 1'b0);
    access_a(1'b0, 15'o12345, 12'o0000, 0, 1'b0);

`ifdef MEMCTL_STATS_EN
    wait_cyc(next_free_a);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    access_a(1'b0, rand_addr(), 12'o0, 0, 1'b0);
    access_a(1'b1, rand_addr(), 12'($urandom), 1, 1'b0);
    access_a(1'b0, rand_addr(), 12'o0, 0, 1'b0);
    access_a(1'b1, rand_addr(), 12'($urandom), 0, 1'b0);
    access_a(1'b0, rand_addr(), 12'o0, 2, 1'b0);
    wait_cyc(next_free_a + 1);
    chk("stats_3rd_2wr", {stat_rd_cnt, stat_wr_cnt}, {16'd3, 16'd2});
    access_a(1'b0, rand_addr(), 12'o0, 0, 1'b0);
    wait_cyc(next_free_a - 1);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(posedge clk); #1;
    chk("stats_clr_over_inc", {stat_rd_cnt, stat_wr_cnt}, 32'd0);
`endif

    wait_cyc(next_free_a + 3);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdp8_memctl.md
Name: pdp8_memctl

Overview:
- Memory cycle sequencer between the PDP-8 CPU core and the async SRAM interface block.
- Accepts single-cycle CPU read/write requests and issues address, write data and rd/wr strobes to the SRAM interface with programmable setup, pulse and hold timing.
- On a read, captures data from the SRAM interface during the strobe pulse and returns it with a one-cycle acknowledge.
- Guarantees the async SRAM never sees address or data changing while a strobe is active.

Parameters:
- SETUP_CYC, 1, cycles from address/data valid until strobe asserts (4-bit; 0 treated as 1).
- PULSE_CYC, 2, cycles the rd or wr strobe stays asserted (4-bit; 0 treated as 1).
- HOLD_CYC, 1, cycles address/data are held after the strobe drops (4-bit; 0 treated as 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  single-cycle request pulse; accepted only when cpu_busy=0
- cpu_wr  in  1  1=write, 0=read; sampled with cpu_req
- cpu_addr  in  15  {field[2:0], addr[11:0]}; sampled with cpu_req
- cpu_wdata  in  12  write data; sampled with cpu_req
- cpu_rdata  out  12  read data; valid from the cpu_ack cycle until the next read's ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_busy  out  1  high from the cycle after acceptance through the ACK cycle
- ram_addr  out  15  address to the SRAM interface
- ram_wdata  out  12  write data to the SRAM interface
- ram_rdata  in  12  read data from the SRAM interface
- ram_rd  out  1  read strobe (active high)
- ram_wr  out  1  write strobe (active high)

Behaviour:
- All outputs are registered. Reset values: cpu_rdata=0, cpu_ack=0, cpu_busy=0, ram_addr=0, ram_wdata=0, ram_rd=0, ram_wr=0. The FSM resets to IDLE.
- FSM states: IDLE, SETUP, PULSE, HOLD, ACK. A 4-bit down-counter times SETUP, PULSE and HOLD.
- IDLE:
  - If cpu_req=1, latch cpu_wr, cpu_addr and cpu_wdata into ram_addr/ram_wdata, set cpu_busy=1, load the counter with SETUP_CYC, and go to SETUP.
  - If cpu_req=0, stay in IDLE.
- SETUP:
  - Decrement the counter. On expiry, assert ram_rd (read) or ram_wr (write), load PULSE_CYC, and go to PULSE.
- PULSE:
  - The strobe stays high. Decrement the counter.
  - On the last pulse cycle of a read, capture ram_rdata into an internal holding register.
  - On expiry, drop the strobe, load HOLD_CYC, and go to HOLD.
- HOLD:
  - ram_addr/ram_wdata stay unchanged. On expiry go to ACK.
  - For a read, the captured value is transferred to cpu_rdata on entry to ACK.
- ACK:
  - cpu_ack=1 for exactly one cycle; cpu_busy deasserts on the following cycle.
  - Return to IDLE. A cpu_req in that IDLE cycle is accepted.
- Latency: cpu_ack asserts 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles after the cpu_req cycle. Defaults give 5.
- Back-to-back throughput is 2+S+P+H cycles per access.
- cpu_req while cpu_busy=1 is ignored: no queueing, no error.
- ram_rd and ram_wr are never high simultaneously.
- ram_addr/ram_wdata change only in IDLE on acceptance, never while a strobe is high.
- Writes leave cpu_rdata unchanged.
- Reset asserted mid-access: strobes, ack and busy clear immediately (asynchronously) and the FSM returns to IDLE. The aborted access is not acknowledged.
- Address and data pass through unmodified, full width, with no arithmetic.

Optional Feature:
- Macro: MEMCTL_STATS_EN.
- With it:
  - Adds output ports stat_rd_cnt[15:0] and stat_wr_cnt[15:0], plus input stat_clr.
  - Each counter increments by 1 in the ACK cycle of a read or write respectively.
  - Counters wrap from 0xFFFF to 0x0000.
  - stat_clr=1 synchronously zeroes both counters and takes priority over a same-cycle increment.
  - reset_n clears both counters.
- Without it: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle: hold reset_n=0 → all outputs 0. Release with no cpu_req for 10 cycles → cpu_busy and both strobes stay 0.
- Write, default timing: cpu_req=1, cpu_wr=1, addr=15'o12345, wdata=12'o7070 at cycle 0 → ram_addr=12345 and ram_wdata=7070 from cycle 1; ram_wr high in cycles 2–3 only; cpu_ack at cycle 5; ram_rd never high.
- Read, default timing: SRAM model returns 12'o4321 for addr 15'o00200 → ram_rd high in cycles 2–3; cpu_ack at cycle 5 with cpu_rdata=4321; cpu_rdata holds 4321 through a following write.
- Parameter sweep and ignored request: run with SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=0 → ack at cycle 1+2+3+1=7. A second cpu_req pulsed at cycle 3 is ignored, so only one ack occurs.
- Back-to-back and mid-access reset:
  - Issue cpu_req in the IDLE cycle right after ack → accepted, and the second ack arrives 6 cycles after the first.
  - Pulse reset_n=0 while ram_rd is high → ram_rd drops in the same cycle, no ack follows, and the next request completes normally.
- Stats (MEMCTL_STATS_EN defined): 3 reads and 2 writes → stat_rd_cnt=3, stat_wr_cnt=2. stat_clr in the ACK cycle of a read → both counters 0.
